eee_bbox_multi: RTL and testbench

EEE_BBOX_MULTI -- requirements
Module: eee_bbox_multi

---
 rtl/eee_bbox_pkg.sv | 23 ++
 rtl/eee_bbox_chan.sv | 103 ++++++++++
 rtl/eee_bbox_multi.sv | 162 ++++++++++++++++
 tb/tb_eee_bbox_multi.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eee_bbox_pkg.sv
// Shared types and constants for the multi-channel bounding-box tracker.
// Holds the packet-FSM encoding, the video packet type and the highlight palette.
package eee_bbox_pkg;

   localparam int PIX_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_TYPE_WAIT = 2'd1,
      ST_VIDEO     = 2'd2,
      ST_CTRL      = 2'd3
   } bbox_state_e;

   localparam logic [3:0] VIDEO_TYPE = 4'h0;

   // Entry 0 is channel 0; channels 3 and above share the last entry.
   localparam logic [3:0][PIX_W-1:0] HL_TABLE = {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};

   function automatic logic [PIX_W-1:0] hl_colour(input int ch);
      return (ch > 2) ? HL_TABLE[3] : HL_TABLE[2'(ch)];
   endfunction

endpackage

// File: rtl/eee_bbox_chan.sv
// One colour channel: RGB window comparator, shadow/active thresholds,
// running bounding box and pixel count, plus the published result registers.
module eee_bbox_chan
   import eee_bbox_pkg::*;
#(
   parameter int CW = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_min,
   input  logic             wr_max,
   input  logic [PIX_W-1:0] cfg_data,
   input  logic             vid_sop,
   input  logic             acc_en,
   input  logic [CW-1:0]    x,
   input  logic [CW-1:0]    y,
   input  logic [PIX_W-1:0] pix,
   input  logic             publish,
   output logic             match,
   output logic [4*CW-1:0]  res_bbox,
   output logic [2*CW-1:0]  res_count
);

   logic [PIX_W-1:0] min_sh_q, max_sh_q, min_q, max_q;
   logic [2*CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]    xmin_q, ymin_q, xmax_q, ymax_q;
   logic [CW-1:0]    xmin_d, ymin_d, xmax_d, ymax_d;
   logic [4*CW-1:0]  res_bbox_q;
   logic [2*CW-1:0]  res_count_q;
   logic [2:0]       comp_ok;

   for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
      assign comp_ok[gi] = (pix[8*gi +: 8] >= min_q[8*gi +: 8]) &&
                           (pix[8*gi +: 8] <= max_q[8*gi +: 8]);
   end
   assign match = &comp_ok;

   always_comb begin
      cnt_d  = cnt_q;
      xmin_d = xmin_q;
      ymin_d = ymin_q;
      xmax_d = xmax_q;
      ymax_d = ymax_q;
      if (vid_sop) begin
         cnt_d  = '0;
         xmin_d = '0;
         ymin_d = '0;
         xmax_d = '0;
         ymax_d = '0;
      end else if (acc_en && match) begin
         cnt_d = cnt_q + 1'b1;
         // The first hit of a frame seeds all four edges.
         if (cnt_q == '0) begin
            xmin_d = x;
            ymin_d = y;
            xmax_d = x;
            ymax_d = y;
         end else begin
            if (x < xmin_q) xmin_d = x;
            if (y < ymin_q) ymin_d = y;
            if (x > xmax_q) xmax_d = x;
            if (y > ymax_q) ymax_d = y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         min_sh_q    <= '1;
         max_sh_q    <= '0;
         min_q       <= '1;
         max_q       <= '0;
         cnt_q       <= '0;
         xmin_q      <= '0;
         ymin_q      <= '0;
         xmax_q      <= '0;
         ymax_q      <= '0;
         res_bbox_q  <= '0;
         res_count_q <= '0;
      end else begin
         if (wr_min) min_sh_q <= cfg_data;
         if (wr_max) max_sh_q <= cfg_data;
         // A write landing on the sop cycle bypasses the shadow so it takes effect now.
         if (vid_sop) begin
            min_q <= wr_min ? cfg_data : min_sh_q;
            max_q <= wr_max ? cfg_data : max_sh_q;
         end
         cnt_q  <= cnt_d;
         xmin_q <= xmin_d;
         ymin_q <= ymin_d;
         xmax_q <= xmax_d;
         ymax_q <= ymax_d;
         if (publish) begin
            res_count_q <= cnt_d;
            res_bbox_q  <= (cnt_d == '0) ? '0 : {xmin_d, ymin_d, xmax_d, ymax_d};
         end
      end
   end

   assign res_bbox  = res_bbox_q;
   assign res_count = res_count_q;

endmodule

// File: rtl/eee_bbox_multi.sv
// Avalon-ST video pass-through that tracks per-channel colour bounding boxes
// and optionally repaints matching pixels with the channel colour.
module eee_bbox_multi
   import eee_bbox_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int NCH   = 4,
   parameter int CW    = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [23:0]            sink_data,
   input  logic                   sink_valid,
   output logic                   sink_ready,
   input  logic                   sink_sop,
   input  logic                   sink_eop,
   output logic [23:0]            source_data,
   output logic                   source_valid,
   input  logic                   source_ready,
   output logic                   source_sop,
   output logic                   source_eop,
   input  logic                   cfg_wr,
   input  logic [$clog2(NCH):0]   cfg_addr,
   input  logic [23:0]            cfg_data,
   input  logic                   hl_en,
   output logic                   res_valid,
   output logic [NCH*4*CW-1:0]    res_bbox,
   output logic [NCH*2*CW-1:0]    res_count,
   output logic                   frame_err
);

   localparam int FRAME_PIX = IMG_W * IMG_H;
   localparam int PW        = $clog2(FRAME_PIX + 2);
   localparam logic [PW-1:0] FRAME_PIX_P = PW'(FRAME_PIX);

   bbox_state_e       state_q, state_d;
   logic              type_vid_q, type_vid_d;
   logic [CW-1:0]     x_q, x_d, y_q, y_d;
   logic [PW-1:0]     pcnt_q, pcnt_d, pcnt_inc;
   logic              xfer, vid_sop, pix_en, acc_en, publish, err;
   logic [NCH-1:0]    match;
   logic [23:0]       out_data;
   logic [23:0]       src_data_q;
   logic              src_valid_q, src_sop_q, src_eop_q, res_valid_q, frame_err_q;

   assign sink_ready = source_ready | ~src_valid_q;
   assign xfer       = sink_valid & sink_ready;
   assign vid_sop    = xfer & sink_sop & (sink_data[3:0] == VIDEO_TYPE);
   assign pix_en     = xfer & ~sink_sop &
                       ((state_q == ST_VIDEO) | ((state_q == ST_TYPE_WAIT) & type_vid_q));
   assign acc_en     = pix_en & (y_q < CW'(IMG_H));
   // Saturates one past a full frame so oversize frames can never alias to exact.
   assign pcnt_inc   = (pcnt_q > FRAME_PIX_P) ? pcnt_q : pcnt_q + PW'(1);
   assign publish    = pix_en & sink_eop & (pcnt_inc == FRAME_PIX_P);
   assign err        = (xfer & sink_sop & ((state_q == ST_VIDEO) | (state_q == ST_CTRL))) |
                       (pix_en & sink_eop & (pcnt_inc != FRAME_PIX_P));

   always_comb begin
      state_d    = state_q;
      type_vid_d = type_vid_q;
      x_d        = x_q;
      y_d        = y_q;
      pcnt_d     = pcnt_q;
      if (xfer) begin
         if (sink_sop) begin
            state_d    = sink_eop ? ST_IDLE : ST_TYPE_WAIT;
            type_vid_d = (sink_data[3:0] == VIDEO_TYPE);
            if (vid_sop) begin
               x_d    = '0;
               y_d    = '0;
               pcnt_d = '0;
            end
         end else begin
            case (state_q)
               ST_TYPE_WAIT: state_d = sink_eop ? ST_IDLE : (type_vid_q ? ST_VIDEO : ST_CTRL);
               ST_VIDEO, ST_CTRL: if (sink_eop) state_d = ST_IDLE;
               default: ;
            endcase
            if (pix_en) begin
               pcnt_d = pcnt_inc;
               if (x_q == CW'(IMG_W - 1)) begin
                  x_d = '0;
                  if (y_q != '1) y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      out_data = sink_data;
      if (pix_en && hl_en) begin
         for (int c = NCH - 1; c >= 0; c--) begin
            if (match[c]) out_data = hl_colour(c);
         end
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic sel;
      assign sel = cfg_wr & (int'(cfg_addr >> 1) == gi);
      eee_bbox_chan #(.CW(CW)) u_chan (
         .clk      (clk),
         .reset    (reset),
         .wr_min   (sel & ~cfg_addr[0]),
         .wr_max   (sel & cfg_addr[0]),
         .cfg_data (cfg_data),
         .vid_sop  (vid_sop),
         .acc_en   (acc_en),
         .x        (x_q),
         .y        (y_q),
         .pix      (sink_data),
         .publish  (publish),
         .match    (match[gi]),
         .res_bbox (res_bbox[gi*4*CW +: 4*CW]),
         .res_count(res_count[gi*2*CW +: 2*CW])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         type_vid_q  <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         pcnt_q      <= '0;
         src_data_q  <= '0;
         src_valid_q <= 1'b0;
         src_sop_q   <= 1'b0;
         src_eop_q   <= 1'b0;
         res_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_vid_q  <= type_vid_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pcnt_q      <= pcnt_d;
         res_valid_q <= publish;
         frame_err_q <= err;
         if (xfer) begin
            src_data_q  <= out_data;
            src_valid_q <= 1'b1;
            src_sop_q   <= sink_sop;
            src_eop_q   <= sink_eop;
         end else if (source_ready) begin
            src_valid_q <= 1'b0;
         end
      end
   end

   assign source_data  = src_data_q;
   assign source_valid = src_valid_q;
   assign source_sop   = src_sop_q;
   assign source_eop   = src_eop_q;
   assign res_valid    = res_valid_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_eee_bbox_multi.sv
// Randomised bench for eee_bbox_multi: drives packets with idle gaps and back-pressure,
// and checks the output stream and per-frame results against a frame-level model.
module tb_eee_bbox_multi;

   localparam int W   = 8;
   localparam int H   = 4;
   localparam int NCH = 2;
   localparam int CW  = 4;
   localparam int AW  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [23:0]       sink_data;
   logic              sink_valid, sink_ready, sink_sop, sink_eop;
   logic [23:0]       source_data;
   logic              source_valid, source_ready, source_sop, source_eop;
   logic              cfg_wr;
   logic [AW-1:0]     cfg_addr;
   logic [23:0]       cfg_data;
   logic              hl_en;
   logic              res_valid, frame_err;
   logic [NCH*4*CW-1:0] res_bbox;
   logic [NCH*2*CW-1:0] res_count;

   eee_bbox_multi #(.IMG_W(W), .IMG_H(H), .NCH(NCH), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
      .sink_sop(sink_sop), .sink_eop(sink_eop),
      .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
      .source_sop(source_sop), .source_eop(source_eop),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .hl_en(hl_en),
      .res_valid(res_valid), .res_bbox(res_bbox), .res_count(res_count),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int n_valid = 0, n_err = 0, exp_valid = 0, exp_err = 0;
   bit tog_mode = 1'b0;
   int gap_max = 0;
   logic [25:0] got_q[$], exp_q[$];
   logic [23:0] pix_buf[64];
   logic [23:0] first_pix_out;

   // Frame-level reference model state
   logic [23:0] sh_min[NCH], sh_max[NCH], ac_min[NCH], ac_max[NCH];
   int m_state, m_video, m_idx;
   int m_cnt[NCH], m_xmin[NCH], m_ymin[NCH], m_xmax[NCH], m_ymax[NCH];
   logic [NCH*4*CW-1:0] exp_bbox;
   logic [NCH*2*CW-1:0] exp_count;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      source_ready = tog_mode ? ~source_ready : 1'b1;
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (source_valid && source_ready) got_q.push_back({source_sop, source_eop, source_data});
         if (res_valid) n_valid++;
         if (frame_err) n_err++;
      end
   end

   function automatic logic [23:0] hl_col(input int c);
      case (c)
         0:       return 24'hFF0000;
         1:       return 24'h00FF00;
         2:       return 24'h0000FF;
         default: return 24'hFFFFFF;
      endcase
   endfunction

   function automatic bit pix_match(input int c, input logic [23:0] p);
      logic [7:0] v;
      for (int k = 0; k < 3; k++) begin
         v = p[8*k +: 8];
         if (v < ac_min[c][8*k +: 8] || v > ac_max[c][8*k +: 8]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_word(input logic [23:0] d, input logic s, input logic e);
      logic [23:0] o;
      int x, y, hit;
      o = d;
      if (s) begin
         if (m_state == 2) exp_err++;
         m_video = (d[3:0] == 4'h0);
         if (m_video != 0) begin
            for (int c = 0; c < NCH; c++) begin
               ac_min[c] = sh_min[c];
               ac_max[c] = sh_max[c];
               m_cnt[c]  = 0;
            end
            m_idx = 0;
         end
         m_state = e ? 0 : 1;
      end else if (m_state != 0) begin
         if (m_video != 0) begin
            x = m_idx % W;
            y = m_idx / W;
            hit = -1;
            for (int c = NCH - 1; c >= 0; c--) begin
               if (pix_match(c, d)) begin
                  hit = c;
                  if (y < H) begin
                     if (m_cnt[c] == 0) begin
                        m_xmin[c] = x; m_xmax[c] = x; m_ymin[c] = y; m_ymax[c] = y;
                     end else begin
                        if (x < m_xmin[c]) m_xmin[c] = x;
                        if (x > m_xmax[c]) m_xmax[c] = x;
                        if (y < m_ymin[c]) m_ymin[c] = y;
                        if (y > m_ymax[c]) m_ymax[c] = y;
                     end
                     m_cnt[c]++;
                  end
               end
            end
            if (hl_en && hit >= 0) o = hl_col(hit);
            m_idx++;
            if (e) begin
               if (m_idx == W * H) begin
                  exp_valid++;
                  for (int c = 0; c < NCH; c++) begin
                     exp_count[c*2*CW +: 2*CW] = (2*CW)'(m_cnt[c]);
                     exp_bbox[c*4*CW +: 4*CW] = (m_cnt[c] == 0) ? '0 :
                        {CW'(m_xmin[c]), CW'(m_ymin[c]), CW'(m_xmax[c]), CW'(m_ymax[c])};
                  end
               end else begin
                  exp_err++;
               end
            end
         end
         m_state = e ? 0 : 2;
      end
      exp_q.push_back({s, e, o});
   endtask

   task automatic send_word(input logic [23:0] d, input logic s, input logic e);
      bit done;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (sink_ready) done = 1'b1;
         else begin @(posedge clk); #1; end
      end
      if (!done) check_val("sink_stall", 0, 1);
      @(posedge clk); #1;
      sink_valid = 1'b0;
      model_word(d, s, e);
   endtask

   task automatic cfg_write(input int ch, input bit is_max, input logic [23:0] d);
      cfg_addr = AW'(ch * 2 + int'(is_max));
      cfg_data = d;
      cfg_wr   = 1'b1;
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      if (is_max) sh_max[ch] = d; else sh_min[ch] = d;
   endtask

   task automatic send_pixels(input int from, input int upto, input bit last_eop);
      for (int i = from; i < upto; i++)
         send_word(pix_buf[i], 1'b0, last_eop && (i == upto - 1));
   endtask

   task automatic fill_random(input int n, input logic [23:0] mask);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) pix_buf[i] = 24'hFF0000 | ($urandom & 24'h003F3F);
         else pix_buf[i] = $urandom & mask;
      end
   endtask

   task automatic check_packets(input string name);
      for (int k = 0; k < 2000; k++) begin
         if (got_q.size() >= exp_q.size()) break;
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      #1;
      check_val({name, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_val({name, "_word"}, got_q[i], exp_q[i]);
      if (got_q.size() > 1) first_pix_out = got_q[1][23:0];
      check_val({name, "_nvalid"}, n_valid, exp_valid);
      check_val({name, "_nerr"}, n_err, exp_err);
      check_val({name, "_bbox"}, res_bbox, exp_bbox);
      check_val({name, "_count"}, res_count, exp_count);
      $display("pkt %s: words=%0d res_valid=%0d frame_err=%0d", name, got_q.size(), n_valid, n_err);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0;
      cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; hl_en = 1'b0; source_ready = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         sh_min[c] = 24'hFFFFFF; sh_max[c] = 24'h000000;
         ac_min[c] = 24'hFFFFFF; ac_max[c] = 24'h000000;
         m_cnt[c] = 0;
      end
      m_state = 0; m_video = 0; m_idx = 0; exp_bbox = '0; exp_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_src_valid", source_valid, 0);
      check_val("rst_src_data", source_data, 0);
      check_val("rst_src_sop", source_sop, 0);
      check_val("rst_src_eop", source_eop, 0);
      check_val("rst_res_valid", res_valid, 0);
      check_val("rst_frame_err", frame_err, 0);
      check_val("rst_res_bbox", res_bbox, 0);
      check_val("rst_res_count", res_count, 0);
      check_val("rst_sink_ready", sink_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;

      // Two red pixels in ch0's window, channel 1 left at reset thresholds
      cfg_write(0, 0, 24'h800000);
      cfg_write(0, 1, 24'hFF7F7F);
      for (int i = 0; i < 32; i++) pix_buf[i] = $urandom & 24'h7FFFFF;
      pix_buf[1*W + 2] = 24'hFF0000;
      pix_buf[3*W + 5] = 24'hFF0000;
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 32, 1'b1);
      check_packets("basic");
      check_val("basic_bbox0", res_bbox[15:0], 16'h2153);
      check_val("basic_count0", res_count[7:0], 2);
      check_val("basic_bbox1", res_bbox[31:16], 0);
      check_val("basic_count1", res_count[15:8], 0);

      // Short frame: error pulse, previous results held
      fill_random(30, 24'hFFFFFF);
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 30, 1'b1);
      check_packets("short");
      check_val("short_held_bbox0", res_bbox[15:0], 16'h2153);
      check_val("short_held_count0", res_count[7:0], 2);

      // Control packet is forwarded bit-exact, then a video frame
      send_word(24'hABCD0F, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, i == 3);
      fill_random(32, 24'hFFFFFF);
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 32, 1'b1);
      check_packets("ctrl_video");

      // Threshold change mid-frame applies only from the next frame
      fill_random(32, 24'hFFFFFF);
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 16, 1'b0);
      cfg_write(0, 0, 24'h000000);
      cfg_write(0, 1, 24'hFFFFFF);
      send_pixels(16, 32, 1'b1);
      check_packets("cfg_old");
      fill_random(32, 24'hFFFFFF);
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 32, 1'b1);
      check_packets("cfg_new");
      check_val("cfg_new_count0", res_count[7:0], 32);
      check_val("cfg_new_bbox0", res_bbox[15:0], 16'h0073);

      // New sop mid-frame abandons the frame
      fill_random(32, 24'hFFFFFF);
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 10, 1'b0);
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 32, 1'b1);
      check_packets("abandon");

      // Highlight: overlapping channels resolve to the lowest one
      cfg_write(0, 0, 24'h800000);
      cfg_write(0, 1, 24'hFF7F7F);
      cfg_write(1, 0, 24'h000000);
      cfg_write(1, 1, 24'hFFFFFF);
      hl_en = 1'b1;
      fill_random(32, 24'hFFFFFF);
      pix_buf[0] = 24'hFF1020;
      send_word(24'h000000, 1'b1, 1'b0);
      send_pixels(0, 32, 1'b1);
      check_packets("highlight");
      check_val("hl_overlap_red", first_pix_out, 24'hFF0000);

      // Back-pressure toggling with random idle gaps and random windows
      tog_mode = 1'b1;
      gap_max  = 3;
      for (int f = 0; f < 4; f++) begin
         hl_en = $urandom_range(0, 1);
         cfg_write(1, 0, $urandom & 24'h7F7F7F);
         cfg_write(1, 1, $urandom | 24'h808080);
         fill_random(32, 24'hFFFFFF);
         send_word(24'h000000, 1'b1, 1'b0);
         send_pixels(0, 32, 1'b1);
         check_packets("stress");
      end
      tog_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
